// File: rtl/fa32_cla.sv
// fa32_cla: two-level carry-lookahead adder/subtractor with registered outputs.
//
// Cin doubles as the subtract select: Cin=0 gives A+B, Cin=1 gives A-B (A + ~B + 1).
// All outputs are registered, one clock of latency, a new operation every cycle.
// In subtract mode Cout=1 means no borrow (A >= B unsigned).
//
// Parameters:
//   WIDTH  operand/sum width, must be a multiple of BLK
//   BLK    width of each first-level lookahead block
//
// Ports:
//   clk   in   clock, rising edge
//   rst   in   synchronous reset, active high; clears all outputs
//   A     in   operand A
//   B     in   operand B
//   Cin   in   carry-in / subtract select
//   S     out  registered sum/difference
//   Cout  out  registered carry-out of the MSB
//   PG    out  registered group propagate (AND of all A^Bx bits)
//   GG    out  registered group generate (independent of Cin except through Bx)
//   OVF   out  registered signed overflow; present only when FA32_OVF_EN is defined
//
// Optional feature macro: FA32_OVF_EN
module fa32_cla #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BLK   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             PG,
  output logic             GG
`ifdef FA32_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int unsigned NBLK = WIDTH / BLK;

  // Carry into position n of a (p, g) vector with carry-in ci, written as the flat
  // sum-of-products g[n-1] | p[n-1]g[n-2] | ... | p[n-1..0]ci so no ripple chain forms.
  function automatic logic la_carry(input logic [WIDTH-1:0] p_v,
                                    input logic [WIDTH-1:0] g_v,
                                    input logic             ci,
                                    input int unsigned      n);
    logic c_acc;
    logic term;
    c_acc = 1'b0;
    for (int unsigned k = 0; k < n; k++) begin
      term = g_v[k];
      for (int unsigned m = k + 1; m < n; m++) begin
        term = term & p_v[m];
      end
      c_acc = c_acc | term;
    end
    term = ci;
    for (int unsigned m = 0; m < n; m++) begin
      term = term & p_v[m];
    end
    return c_acc | term;
  endfunction

  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] sum;
  logic [NBLK-1:0]  blk_p;
  logic [NBLK-1:0]  blk_g;
  logic [NBLK-1:0]  blk_cin;
  logic [WIDTH-1:0] loc_p;
  logic [WIDTH-1:0] loc_g;
  logic [WIDTH-1:0] top_p;
  logic [WIDTH-1:0] top_g;
  logic             pg_c;
  logic             gg_c;
  logic             cout_c;

  // First level: per-block propagate/generate.
  always_comb begin
    bx    = B ^ {WIDTH{Cin}};
    p     = A ^ bx;
    g     = A & bx;
    blk_p = '0;
    blk_g = '0;
    loc_p = '0;
    loc_g = '0;
    for (int unsigned b = 0; b < NBLK; b++) begin
      loc_p          = '0;
      loc_g          = '0;
      loc_p[BLK-1:0] = p[b*BLK +: BLK];
      loc_g[BLK-1:0] = g[b*BLK +: BLK];
      blk_p[b]       = &loc_p[BLK-1:0];
      blk_g[b]       = la_carry(loc_p, loc_g, 1'b0, BLK);
    end
  end

  // Second level: block carry-ins, group P/G, then in-block carries from each block carry-in.
  always_comb begin
    top_p             = '0;
    top_g             = '0;
    top_p[NBLK-1:0]   = blk_p;
    top_g[NBLK-1:0]   = blk_g;
    blk_cin           = '0;
    c                 = '0;
    for (int unsigned b = 0; b < NBLK; b++) begin
      blk_cin[b] = la_carry(top_p, top_g, Cin, b);
    end
    for (int unsigned b = 0; b < NBLK; b++) begin
      for (int unsigned j = 0; j < BLK; j++) begin
        c[b*BLK+j] = la_carry({{(WIDTH-BLK){1'b0}}, p[b*BLK +: BLK]},
                              {{(WIDTH-BLK){1'b0}}, g[b*BLK +: BLK]},
                              blk_cin[b], j);
      end
    end
    pg_c   = &blk_p;
    gg_c   = la_carry(top_p, top_g, 1'b0, NBLK);
    cout_c = gg_c | (pg_c & Cin);
    sum    = p ^ c;
  end

  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             pg_q;
  logic             gg_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q    <= '0;
      cout_q <= 1'b0;
      pg_q   <= 1'b0;
      gg_q   <= 1'b0;
    end else begin
      s_q    <= sum;
      cout_q <= cout_c;
      pg_q   <= pg_c;
      gg_q   <= gg_c;
    end
  end

  assign S    = s_q;
  assign Cout = cout_q;
  assign PG   = pg_q;
  assign GG   = gg_q;

`ifdef FA32_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= (A[WIDTH-1] == bx[WIDTH-1]) & (sum[WIDTH-1] != A[WIDTH-1]);
    end
  end

  assign OVF = ovf_q;
`endif

endmodule

// File: tb/tb_fa32_cla.sv
// Scoreboard bench for fa32_cla: the driver pushes the expected registered result for each
// applied operation; a monitor pops and compares one entry after every rising edge.
module tb_fa32_cla;

  logic        clk;
  logic        rst;
  logic [31:0] A;
  logic [31:0] B;
  logic        Cin;
  logic [31:0] S;
  logic        Cout;
  logic        PG;
  logic        GG;
`ifdef FA32_OVF_EN
  logic        OVF;
`endif

  fa32_cla #(
    .WIDTH(32),
    .BLK  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .B   (B),
    .Cin (Cin),
    .S   (S),
    .Cout(Cout),
    .PG  (PG),
    .GG  (GG)
`ifdef FA32_OVF_EN
    ,
    .OVF (OVF)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] s;
    logic        cout;
    logic        pg;
    logic        gg;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference built from plain arithmetic on the operands.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic r);
    exp_t        e;
    logic [31:0] bx;
    logic [32:0] full;
    logic [32:0] nocin;
    longint      ssum;
    e = '0;
    if (r) return e;
    bx     = cin ? ~b : b;
    full   = {1'b0, a} + {1'b0, bx} + {32'd0, cin};
    nocin  = {1'b0, a} + {1'b0, bx};
    e.s    = full[31:0];
    e.cout = full[32];
    e.pg   = ((a ^ bx) == 32'hFFFF_FFFF);
    e.gg   = nocin[32];
    ssum   = longint'($signed(a)) + longint'($signed(bx)) + longint'(cin);
    e.ovf  = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
    return e;
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic cin,
                       input logic r);
    @(negedge clk);
    A   = a;
    B   = b;
    Cin = cin;
    rst = r;
    exp_q.push_back(model(a, b, cin, r));
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %08h want %08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every edge produces a registered result for the operation applied before it.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("S", S, e.s);
      chk("Cout", {31'd0, Cout}, {31'd0, e.cout});
      chk("PG", {31'd0, PG}, {31'd0, e.pg});
      chk("GG", {31'd0, GG}, {31'd0, e.gg});
`ifdef FA32_OVF_EN
      chk("OVF", {31'd0, OVF}, {31'd0, e.ovf});
`endif
    end
  end

  initial begin
    int drain;
    rst = 1'b1;
    A   = '0;
    B   = '0;
    Cin = 1'b0;

    // Reset for two edges with non-zero operands present; the results must stay zero.
    drive(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1);
    drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1);

    drive(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
    drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    drive(32'h0000_0002, 32'h0000_0001, 1'b1, 1'b0);
    drive(32'h0000_0001, 32'h0000_0001, 1'b1, 1'b0);
    drive(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0);
    drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    drive(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
    drive(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b0);
    drive(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0);
    drive(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0);
    drive(32'h0000_000F, 32'h0000_0001, 1'b0, 1'b0);
    drive(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);

    // Back-to-back random traffic with reset pulses mid-stream.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rc;
      logic        rr;
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      if (i % 7 == 3) rb = ~ra;                // long propagate runs
      if (i % 11 == 5) rb = ra;                // A=B cases
      rr = (i == 150) || (i == 151) || (i == 300);
      drive(ra, rb, rc, rr);
    end

    drive(32'h0, 32'h0, 1'b0, 1'b0);

    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d results pending, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
